// File: rtl/shift_counter_if.sv
// Control and status bundle for shift_counter: step controls in, counter state out.
// Latency: none, wiring only.
// Backpressure: none; the counter accepts one control set per clock.
interface shift_counter_if #(
    parameter int N  = 8,
    parameter int IW = $clog2(2*N)
) ();
    logic          en;
    logic          mode;
    logic          dir;
    logic          ld;
    logic [N-1:0]  din;
    logic [N-1:0]  Q;
    logic [IW-1:0] idx;
    logic          wrap;
    logic          fault;

    // Controller side: drives the step controls and observes the counter.
    modport master (
        output en, mode, dir, ld, din,
        input  Q, idx, wrap, fault
    );

    // Counter side.
    modport slave (
        input  en, mode, dir, ld, din,
        output Q, idx, wrap, fault
    );
endinterface

// File: rtl/shift_counter.sv
// Johnson / one-hot ring shift counter with load, self-seeding, illegal-state correction and idx decode.
// Latency: Q, wrap and fault update at the enabled edge; idx follows Q combinationally.
// Backpressure: none; en gates stepping and ld always wins.
module shift_counter #(
    parameter int N  = 8,
    parameter int IW = $clog2(2*N)
) (
    input  logic             clk,
    input  logic             clr,
    shift_counter_if.slave   bus
);
    localparam logic [N-1:0] ZERO = '0;
    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
    // Bit N-1 of (q ^ q>>1) compares against a shifted-in zero, so drop it.
    localparam logic [N-1:0] PAIR_MASK = {1'b0, {(N-1){1'b1}}};

    logic [N-1:0]  q_r;
    logic          wrap_r;
    logic          fault_r;

    logic [N-1:0]  step_q;
    logic          j_legal;
    logic          r_legal;
    logic          legal;
    logic          unseeded;
    logic [IW-1:0] idx_c;
    int            pc;
    int            trans;

    function automatic int popcnt(input logic [N-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            cnt += int'(v[i]);
        end
        return cnt;
    endfunction

    // Classify the current state and decode its step position for the current mode.
    always_comb begin
        pc       = popcnt(q_r);
        trans    = popcnt((q_r ^ (q_r >> 1)) & PAIR_MASK);
        j_legal  = (trans <= 1);
        r_legal  = (pc == 1);
        unseeded = (q_r == ZERO);
        legal    = bus.mode ? r_legal : j_legal;
        idx_c    = '0;
        if (!bus.mode) begin
            if (j_legal) begin
                idx_c = q_r[0] ? IW'(pc) : IW'((2*N - pc) % (2*N));
            end
        end else if (r_legal) begin
            for (int i = 0; i < N; i++) begin
                if (q_r[i]) begin
                    idx_c = IW'(i);
                end
            end
        end
    end

    // Next state for a plain step in the selected mode and direction.
    always_comb begin
        step_q = q_r;
        case ({bus.mode, bus.dir})
            2'b00:   step_q = {q_r[N-2:0], ~q_r[N-1]};
            2'b01:   step_q = {~q_r[0], q_r[N-1:1]};
            2'b10:   step_q = {q_r[N-2:0], q_r[N-1]};
            default: step_q = {q_r[0], q_r[N-1:1]};
        endcase
    end

    // Edge resolution: load, then ring seed, then correction, then step, else hold.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_r     <= ZERO;
            wrap_r  <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            wrap_r  <= 1'b0;
            fault_r <= 1'b0;
            if (bus.ld) begin
                q_r <= bus.din;
            end else if (bus.mode && unseeded) begin
                if (bus.en) begin
                    q_r <= ONE;
                end
            end else if (!legal) begin
                q_r     <= bus.mode ? ONE : ZERO;
                fault_r <= 1'b1;
            end else if (bus.en) begin
                q_r    <= step_q;
                wrap_r <= (step_q == (bus.mode ? ONE : ZERO));
            end
        end
    end

    assign bus.Q     = q_r;
    assign bus.idx   = idx_c;
    assign bus.wrap  = wrap_r;
    assign bus.fault = fault_r;
endmodule

// File: tb/tb_shift_counter.sv
// Self-checking bench for shift_counter (N=4): directed scenarios then randomized traffic.
// Latency: expects Q/wrap/fault one edge after the controls, idx combinational.
// Backpressure: none exercised; controls change once per cycle.
module tb_shift_counter;
    localparam int N  = 4;
    localparam int IW = $clog2(2*N);

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    shift_counter_if #(.N(N), .IW(IW)) bus ();

    shift_counter #(.N(N), .IW(IW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: the counter value plus the two pulse flags.
    logic [N-1:0] mq;
    logic         mw;
    logic         mf;

    // The k-th state of the counting sequence, built directly from its shape.
    function automatic logic [N-1:0] gen(input int k, input logic m);
        logic [N-1:0] one;
        logic [N-1:0] all;
        one = 1;
        all = '1;
        if (m) return one << k;
        if (k <= N) return (one << k) - one;
        return all & ~((one << (k - N)) - one);
    endfunction

    // Position of q in the sequence for mode m, or -1 when q is not a member.
    function automatic int find(input logic [N-1:0] q, input logic m);
        int per;
        per = m ? N : 2*N;
        for (int k = 0; k < per; k++) begin
            if (gen(k, m) == q) return k;
        end
        return -1;
    endfunction

    function automatic int exp_idx(input logic [N-1:0] q, input logic m);
        int k;
        k = find(q, m);
        return (k < 0) ? 0 : k;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic mode, input logic dir,
                         input logic ld, input logic [N-1:0] din);
        bus.en   = en;
        bus.mode = mode;
        bus.dir  = dir;
        bus.ld   = ld;
        bus.din  = din;
    endtask

    // Apply the counter's rules to the reference using the controls present at the edge.
    task automatic model_edge();
        int k;
        int per;
        mw = 1'b0;
        mf = 1'b0;
        if (bus.ld) begin
            mq = bus.din;
        end else if (bus.mode && mq == '0) begin
            if (bus.en) mq = 1;
        end else begin
            k = find(mq, bus.mode);
            per = bus.mode ? N : 2*N;
            if (k < 0) begin
                mq = bus.mode ? 1 : 0;
                mf = 1'b1;
            end else if (bus.en) begin
                k  = bus.dir ? (k + per - 1) % per : (k + 1) % per;
                mq = gen(k, bus.mode);
                mw = (k == 0);
            end
        end
    endtask

    task automatic check_all();
        check("Q",     32'(bus.Q),     32'(mq));
        check("idx",   32'(bus.idx),   32'(exp_idx(mq, bus.mode)));
        check("wrap",  32'(bus.wrap),  32'(mw));
        check("fault", 32'(bus.fault), 32'(mf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Pulse reset between edges and confirm it acts without a clock edge.
    task automatic async_reset();
        #2;
        clr = 1'b0;
        #1;
        mq = '0;
        mw = 1'b0;
        mf = 1'b0;
        check("rst_Q",     32'(bus.Q),     32'd0);
        check("rst_idx",   32'(bus.idx),   32'd0);
        check("rst_wrap",  32'(bus.wrap),  32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        #1;
        clr = 1'b1;
    endtask

    logic [N-1:0] jup  [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [N-1:0] jdn  [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    logic [N-1:0] ring [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        logic         r_en;
        logic         r_mode;
        logic         r_dir;
        logic         r_ld;
        logic [N-1:0] r_din;
        logic [N-1:0] held;

        clr = 1'b0;
        drive(0, 0, 0, 0, '0);
        mq = '0;
        mw = 1'b0;
        mf = 1'b0;
        #12;
        check("init_Q",     32'(bus.Q),     32'd0);
        check("init_idx",   32'(bus.idx),   32'd0);
        check("init_wrap",  32'(bus.wrap),  32'd0);
        check("init_fault", 32'(bus.fault), 32'd0);
        clr = 1'b1;

        // Johnson up through a full revolution.
        drive(1, 0, 0, 0, '0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("jup_Q",    32'(bus.Q),    32'(jup[i]));
            check("jup_idx",  32'(bus.idx),  32'((i + 1) % 8));
            check("jup_wrap", 32'(bus.wrap), 32'(i == 7));
        end

        // Johnson down through a full revolution.
        drive(1, 0, 1, 0, '0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("jdn_Q",    32'(bus.Q),    32'(jdn[i]));
            check("jdn_wrap", 32'(bus.wrap), 32'(i == 7));
        end

        // Ring from reset: seed without wrap, then wrap on return to home.
        async_reset();
        drive(1, 1, 0, 0, '0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ring_Q",    32'(bus.Q),    32'(ring[i]));
            check("ring_idx",  32'(bus.idx),  32'(i % 4));
            check("ring_wrap", 32'(bus.wrap), 32'(i == 4));
        end

        // Illegal Johnson state corrected to zero with a fault pulse.
        drive(0, 0, 0, 1, 4'b0101);
        tick();
        check("ill_ld_Q",   32'(bus.Q),   32'h5);
        check("ill_ld_idx", 32'(bus.idx), 32'd0);
        drive(0, 0, 0, 0, '0);
        tick();
        check("jfix_Q",     32'(bus.Q),     32'd0);
        check("jfix_fault", 32'(bus.fault), 32'd1);
        tick();
        check("jfix_fault_clr", 32'(bus.fault), 32'd0);

        // Illegal ring state corrected to one.
        drive(0, 1, 0, 1, 4'b0110);
        tick();
        drive(0, 1, 0, 0, '0);
        tick();
        check("rfix_Q",     32'(bus.Q),     32'd1);
        check("rfix_fault", 32'(bus.fault), 32'd1);
        check("rfix_wrap",  32'(bus.wrap),  32'd0);

        // Hold with en=0, then load beating an enabled step.
        drive(0, 0, 0, 0, '0);
        held = bus.Q;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_Q", 32'(bus.Q), 32'(held));
        end
        drive(1, 0, 0, 1, 4'b0011);
        tick();
        check("ld_Q",    32'(bus.Q),    32'h3);
        check("ld_idx",  32'(bus.idx),  32'd2);
        check("ld_wrap", 32'(bus.wrap), 32'd0);

        // Asynchronous reset mid-count, then resume from zero.
        drive(1, 0, 0, 0, '0);
        tick();
        check("pre_rst_Q", 32'(bus.Q), 32'h7);
        async_reset();
        tick();
        check("resume_Q", 32'(bus.Q), 32'h1);

        // Randomized traffic against the reference.
        r_mode = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r_en  = ($urandom_range(3) != 0);
            r_dir = $urandom_range(1);
            r_ld  = ($urandom_range(7) == 0);
            r_din = N'($urandom);
            if ($urandom_range(15) == 0) r_mode = ~r_mode;
            drive(r_en, r_mode, r_dir, r_ld, r_din);
            tick();
            if ($urandom_range(49) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
